pp_accum_16b: RTL and testbench

PP_ACCUM_16B -- requirements
Module: pp_accum_16b

---
 rtl/pp_accum_pkg.sv | 21 ++
 rtl/pp_accum_16b_cla.sv | 31 +++
 rtl/pp_accum_16b.sv | 144 ++++++++++++++
 tb/tb_pp_accum_16b.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pp_accum_pkg.sv
// Shared types and constants for the 16-bit partial-product accumulator.
// Enables nothing by itself; see pp_accum_16b for the PP_ACCUM_SAT_EN option.
package pp_accum_pkg;

  localparam int WIDTH = 16;
  localparam int HALF  = 8;
  localparam int SLICE = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    OUT    = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pp_accum_16b_cla.sv
// 4-bit carry-lookahead adder slice: all internal carries are computed
// directly from generate/propagate terms rather than rippled.
module cla_slice_4b
  import pp_accum_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];

endmodule

// File: rtl/pp_accum_16b.sv
// Accumulates sets of 16-bit partial products one byte per cycle on a shared
// 8-bit CLA adder. Define PP_ACCUM_SAT_EN to saturate at 16'hFFFF on overflow.
module pp_accum_16b
  import pp_accum_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pp,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_ovf,
  output logic [7:0]  out_cnt
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   pp_q, pp_d;
  logic               last_q, last_d;
  logic               c8_q, c8_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               hi_sel;
  logic [HALF-1:0]    add_a;
  logic [HALF-1:0]    add_b;
  logic               add_cin;
  logic [HALF-1:0]    add_sum;
  logic               mid_c;
  logic               add_cout;

  // Low byte of the sum once a carry out of bit 15 has been seen in this set.
  function automatic logic [HALF-1:0] lo_update(input logic [HALF-1:0] acc_lo,
                                                input logic [HALF-1:0] sum,
                                                input logic            sticky);
`ifdef PP_ACCUM_SAT_EN
    return sticky ? acc_lo : sum;
`else
    return (sticky & 1'b0) ? acc_lo : sum;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] hi_update(input logic [WIDTH-1:0] acc,
                                                 input logic [HALF-1:0]  sum,
                                                 input logic             ovf_any);
`ifdef PP_ACCUM_SAT_EN
    return ovf_any ? {WIDTH{1'b1}} : {sum, acc[HALF-1:0]};
`else
    return (ovf_any & 1'b0) ? {WIDTH{1'b1}} : {sum, acc[HALF-1:0]};
`endif
  endfunction

  // One 8-bit adder serves both halves; c8 feeds the high byte only.
  assign hi_sel  = (state_q == ADD_HI);
  assign add_a   = hi_sel ? acc_q[WIDTH-1:HALF] : acc_q[HALF-1:0];
  assign add_b   = hi_sel ? pp_q[WIDTH-1:HALF]  : pp_q[HALF-1:0];
  assign add_cin = hi_sel & c8_q;

  cla_slice_4b u_cla_lo (
    .a    (add_a[SLICE-1:0]),
    .b    (add_b[SLICE-1:0]),
    .cin  (add_cin),
    .sum  (add_sum[SLICE-1:0]),
    .cout (mid_c)
  );

  cla_slice_4b u_cla_hi (
    .a    (add_a[HALF-1:SLICE]),
    .b    (add_b[HALF-1:SLICE]),
    .cin  (mid_c),
    .sum  (add_sum[HALF-1:SLICE]),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pp_d    = pp_q;
    last_d  = last_q;
    c8_d    = c8_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCEPT: begin
        if (in_valid) begin
          pp_d    = in_pp;
          last_d  = in_last;
          cnt_d   = cnt_inc_sat(cnt_q);
          state_d = ADD_LO;
        end
      end
      ADD_LO: begin
        acc_d[HALF-1:0] = lo_update(acc_q[HALF-1:0], add_sum, ovf_q);
        c8_d            = add_cout;
        state_d         = ADD_HI;
      end
      ADD_HI: begin
        acc_d   = hi_update(acc_q, add_sum, ovf_q | add_cout);
        ovf_d   = ovf_q | add_cout;
        state_d = last_q ? OUT : ACCEPT;
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          c8_d    = 1'b0;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      acc_q   <= '0;
      pp_q    <= '0;
      last_q  <= 1'b0;
      c8_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pp_q    <= pp_d;
      last_q  <= last_d;
      c8_q    <= c8_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == OUT);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_pp_accum_16b.sv
// Directed-vector bench for pp_accum_16b; expectations follow PP_ACCUM_SAT_EN
// when the bench is built with the same define as the design.
module tb_pp_accum_16b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pp;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_cnt;

  int n_cmp;
  int n_mis;

  pp_accum_16b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pp     (in_pp),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] pp, input logic last);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check_eq("send_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_pp    = pp;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_pp    = 16'h0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] sum,
                               input logic ovf, input logic [7:0] cnt);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_sum"},   32'(out_sum),   32'(sum));
    check_eq({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    check_eq({tag, "_cnt"},   32'(out_cnt),   32'(cnt));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_drop"},  32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ovf_sum_exp;
    n_cmp     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pp     = 16'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef PP_ACCUM_SAT_EN
    ovf_sum_exp = 16'hFFFF;
`else
    ovf_sum_exp = 16'h0001;
`endif

    #2;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_sum",   32'(out_sum),   32'd0);
    check_eq("rst_out_ovf",   32'(out_ovf),   32'd0);
    check_eq("rst_out_cnt",   32'(out_cnt),   32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // Single term with exact latency: out_valid rises after the third edge.
    send(16'h1234, 1'b1);
    check_eq("lat_addlo_valid", 32'(out_valid), 32'd0);
    check_eq("lat_addlo_ready", 32'(in_ready),  32'd0);
    step();
    check_eq("lat_addhi_valid", 32'(out_valid), 32'd0);
    step();
    check_eq("lat_out_valid",   32'(out_valid), 32'd1);
    check_eq("lat_out_ready",   32'(in_ready),  32'd0);
    expect_result("single", 16'h1234, 1'b0, 8'd1);

    send(16'h00FF, 1'b0);
    send(16'h0001, 1'b1);
    expect_result("byte_carry", 16'h0100, 1'b0, 8'd2);

    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b1);
    expect_result("three_terms", 16'h6666, 1'b0, 8'd3);

    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
    expect_result("overflow", ovf_sum_exp, 1'b1, 8'd2);

    // Backpressure with junk offered on the input, which must be ignored.
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b1);
    while (!out_valid) step();
    in_valid = 1'b1;
    in_pp    = 16'hFFFF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_ready", 32'(in_ready),  32'd0);
      check_eq("bp_sum",   32'(out_sum),   32'h30);
      check_eq("bp_cnt",   32'(out_cnt),   32'd2);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_pp    = 16'h0;
    expect_result("bp_release", 16'h0030, 1'b0, 8'd2);
    send(16'h0005, 1'b1);
    expect_result("after_bp", 16'h0005, 1'b0, 8'd1);

    // Reset while in ADD_HI discards the set.
    send(16'h8000, 1'b1);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready",  32'(in_ready),  32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_sum",   32'(out_sum),   32'd0);
    check_eq("midrst_out_cnt",   32'(out_cnt),   32'd0);
    #2;
    rst_n = 1'b1;
    step();
    check_eq("midrst_no_result", 32'(out_valid), 32'd0);
    send(16'h0003, 1'b1);
    expect_result("post_rst", 16'h0003, 1'b0, 8'd1);

    for (int i = 0; i < 300; i++) send(16'h0001, (i == 299));
    expect_result("cnt_sat", 16'd300, 1'b0, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
